// File: rtl/counter_sequencer.sv
// counter_sequencer: round-robin arbitrated step-command sequencer driving a
// WIDTH-bit up/down counter. One command runs at a time: IDLE -> RUN (N cycles)
// -> DONE (one-cycle done pulse tagged with the requester id) -> IDLE.
//
// Handshake: a command transfers on a rising edge where reqX_valid and
// reqX_ready are both high. ready is combinational, high only in IDLE, only
// for the arbitration winner, and only while reset is released. Requesters
// hold up/steps stable while valid is high and ready is low, and may drop
// valid at any time before the transfer with no effect.
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_up,
    input  logic [STEP_W-1:0] req0_steps,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_up,
    input  logic [STEP_W-1:0] req1_steps,
    output logic              req1_ready,
    output logic [WIDTH-1:0]  Count,
    output logic              UpOrDown,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_count;
    logic              r_up;
    logic [STEP_W-1:0] r_remaining;
    logic              r_id;
    logic              r_last_grant;

    logic              w_any_valid;
    logic              w_gnt_id;
    logic              w_can_accept;
    logic              w_accept;
    logic              w_gnt_up;
    logic [STEP_W-1:0] w_gnt_steps;

    // Arbitration: a lone requester wins; under contention the one that did
    // not win last time is granted, so grants alternate.
    always_comb begin
        w_any_valid  = req0_valid | req1_valid;
        w_gnt_id     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
        w_can_accept = reset & (r_state == IDLE);
        w_accept     = w_can_accept & w_any_valid;
        w_gnt_up     = w_gnt_id ? req1_up : req0_up;
        w_gnt_steps  = w_gnt_id ? req1_steps : req0_steps;
        req0_ready   = w_accept & ~w_gnt_id;
        req1_ready   = w_accept & w_gnt_id;
    end

    // Command sequencing and counter datapath; reset aborts any command
    // silently and leaves requester 0 favoured at the next contention.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_up         <= 1'b0;
            r_remaining  <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_up         <= w_gnt_up;
                        r_remaining  <= w_gnt_steps;
                        r_id         <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_state      <= (w_gnt_steps == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    r_count     <= r_up ? r_count + 1'b1 : r_count - 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == STEP_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are forced low while reset is held, even before the
    // first clock edge has initialised the state register.
    always_comb begin
        busy        = reset & (r_state != IDLE);
        done        = reset & (r_state == DONE);
        done_id     = done & r_id;
        Count       = r_count;
        UpOrDown    = r_up;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: scenario tasks plus a randomized command stream, all
// checked against a transaction-level model of the sequencer (modular count
// arithmetic, round-robin winner, expected-count queue).
`timescale 1ns/1ps
module tb_counter_sequencer;

    logic       Clk;
    logic       reset;
    logic       req0_valid;
    logic       req0_up;
    logic [3:0] req0_steps;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_up;
    logic [3:0] req1_steps;
    logic       req1_ready;
    logic [3:0] Count;
    logic       UpOrDown;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: counter value and the last granted requester.
    logic [3:0] m_count;
    logic       m_last;
    logic [3:0] exp_q[$];

    counter_sequencer #(.WIDTH(4), .STEP_W(4)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_up    (req0_up),
        .req0_steps (req0_steps),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_up    (req1_up),
        .req1_steps (req1_steps),
        .req1_ready (req1_ready),
        .Count      (Count),
        .UpOrDown   (UpOrDown),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: value after walking i steps from start, modulo 16.
    function automatic logic [3:0] walk(input logic [3:0] start, input logic up, input int i);
        int v;
        v = up ? (int'(start) + i) : (int'(start) - i);
        v = ((v % 16) + 16) % 16;
        return 4'(v);
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_req(input int who, input logic v, input logic up, input logic [3:0] steps);
        if (who == 0) begin
            req0_valid = v; req0_up = up; req0_steps = steps;
        end else begin
            req1_valid = v; req1_up = up; req1_steps = steps;
        end
    endtask

    // Runs one uncontended command to completion; used to set up the counter.
    task automatic quiet_cmd(input int who, input logic up, input logic [3:0] steps);
        drive_req(who, 1'b1, up, steps);
        tick();
        drive_req(who, 1'b0, 1'b0, 4'd0);
        repeat (int'(steps) + 1) tick();
        m_count = walk(m_count, up, int'(steps));
        m_last  = (who != 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_req(0, 1'b1, 1'b1, 4'd3);
        drive_req(1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (Count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", Count); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
            n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready}); end
        end
        reset = 1'b1;
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL release_ready: got %b expected 01", {req1_ready, req0_ready}); end
        drive_req(0, 1'b0, 1'b0, 4'd0);
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL drop_valid_ready: got %b expected 0", req0_ready); end
        m_count = 4'd0;
        m_last  = 1'b1;
    endtask

    task automatic test_single_up();
        logic [3:0] start;
        start = m_count;
        drive_req(0, 1'b1, 1'b1, 4'd5);
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b expected 1", req0_ready); end
        tick();
        drive_req(0, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
        n_cmp++; if (Count !== start) begin n_err++; $display("FAIL single_count0: got %0d expected %0d", Count, start); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++; if (Count !== walk(start, 1'b1, i)) begin n_err++; $display("FAIL single_count step %0d: got %0d expected %0d", i, Count, walk(start, 1'b1, i)); end
            n_cmp++; if (done !== (i == 5)) begin n_err++; $display("FAIL single_done step %0d: got %b expected %b", i, done, (i == 5)); end
        end
        n_cmp++; if (done_id !== 1'b0) begin n_err++; $display("FAIL single_done_id: got %b expected 0", done_id); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL single_end_busy_done: got %b expected 00", {busy, done}); end
        n_cmp++; if (Count !== 4'd5) begin n_err++; $display("FAIL single_hold: got %0d expected 5", Count); end
        m_count = walk(start, 1'b1, 5);
        m_last  = 1'b0;
    endtask

    task automatic test_contention();
        quiet_cmd(1, 1'b0, m_count);   // back to 0, requester 1 granted last
        n_cmp++; if (Count !== 4'd0) begin n_err++; $display("FAIL cont_setup: got %0d expected 0", Count); end
        drive_req(0, 1'b1, 1'b1, 4'd3);
        drive_req(1, 1'b1, 1'b0, 4'd2);
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL cont_first_grant: got %b expected 01", {req1_ready, req0_ready}); end
        tick();
        drive_req(0, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL cont_ready_in_run: got %b expected 0", req1_ready); end
            tick();
            n_cmp++; if (Count !== walk(4'd0, 1'b1, i)) begin n_err++; $display("FAIL cont_a_count: got %0d expected %0d", Count, walk(4'd0, 1'b1, i)); end
        end
        n_cmp++; if ({done, done_id} !== 2'b10) begin n_err++; $display("FAIL cont_a_done: got %b expected 10", {done, done_id}); end
        tick();
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL cont_second_grant: got %b expected 1", req1_ready); end
        tick();
        drive_req(1, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++; if (Count !== walk(4'd3, 1'b0, i)) begin n_err++; $display("FAIL cont_b_count: got %0d expected %0d", Count, walk(4'd3, 1'b0, i)); end
        end
        n_cmp++; if ({done, done_id} !== 2'b11) begin n_err++; $display("FAIL cont_b_done: got %b expected 11", {done, done_id}); end
        tick();
        drive_req(0, 1'b1, 1'b1, 4'd1);
        drive_req(1, 1'b1, 1'b1, 4'd1);
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL cont_regrant: got %b expected 01", {req1_ready, req0_ready}); end
        drive_req(0, 1'b0, 1'b0, 4'd0);
        drive_req(1, 1'b0, 1'b0, 4'd0);
        m_count = 4'd1;
        m_last  = 1'b1;
    endtask

    task automatic test_wrap();
        logic [3:0] start;
        logic       dir;
        logic [3:0] n;
        quiet_cmd(0, 1'b1, 4'd13);
        n_cmp++; if (Count !== 4'd14) begin n_err++; $display("FAIL wrap_setup: got %0d expected 14", Count); end
        for (int c = 0; c < 2; c++) begin
            start = m_count;
            dir   = (c == 0);
            n     = (c == 0) ? 4'd3 : 4'd2;
            drive_req(0, 1'b1, dir, n);
            tick();
            drive_req(0, 1'b0, 1'b0, 4'd0);
            for (int i = 1; i <= int'(n); i++) begin
                tick();
                n_cmp++; if (Count !== walk(start, dir, i)) begin n_err++; $display("FAIL wrap_count cmd %0d step %0d: got %0d expected %0d", c, i, Count, walk(start, dir, i)); end
                n_cmp++; if (UpOrDown !== dir) begin n_err++; $display("FAIL wrap_dir cmd %0d: got %b expected %b", c, UpOrDown, dir); end
            end
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done cmd %0d: got %b expected 1", c, done); end
            tick();
            m_count = walk(start, dir, int'(n));
        end
        m_last = 1'b0;
    endtask

    task automatic test_zero_steps();
        drive_req(1, 1'b1, 1'b1, 4'd0);
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b expected 1", req1_ready); end
        tick();
        drive_req(1, 1'b0, 1'b0, 4'd0);
        n_cmp++; if ({done, done_id} !== 2'b11) begin n_err++; $display("FAIL zero_done: got %b expected 11", {done, done_id}); end
        n_cmp++; if (Count !== m_count) begin n_err++; $display("FAIL zero_count: got %0d expected %0d", Count, m_count); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL zero_end: got %b expected 00", {busy, done}); end
        n_cmp++; if (Count !== m_count) begin n_err++; $display("FAIL zero_count_hold: got %0d expected %0d", Count, m_count); end
        m_last = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++; if (Count !== 4'd0) begin n_err++; $display("FAIL midrst_setup: got %0d expected 0", Count); end
        drive_req(0, 1'b1, 1'b0, 4'd10);
        tick();
        drive_req(0, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (Count !== walk(4'd0, 1'b0, i)) begin n_err++; $display("FAIL midrst_count: got %0d expected %0d", Count, walk(4'd0, 1'b0, i)); end
        end
        reset = 1'b0;
        tick();
        n_cmp++; if ({Count, UpOrDown, busy, done} !== 7'd0) begin n_err++; $display("FAIL midrst_cleared: got count=%0d dir=%b busy=%b done=%b expected all 0", Count, UpOrDown, busy, done); end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_no_done: got %b expected 00", {busy, done}); end
        end
        drive_req(0, 1'b1, 1'b1, 4'd1);
        drive_req(1, 1'b1, 1'b1, 4'd1);
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL midrst_grant: got %b expected 01", {req1_ready, req0_ready}); end
        drive_req(0, 1'b0, 1'b0, 4'd0);
        drive_req(1, 1'b0, 1'b0, 4'd0);
        m_count = 4'd0;
        m_last  = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0] sel;
        logic       up0, up1, eu, eid;
        logic [3:0] s0, s1, es;
        logic [3:0] exp_c;
        for (int it = 0; it < 30; it++) begin
            sel = 2'($urandom_range(1, 3));
            up0 = 1'($urandom_range(0, 1));
            up1 = 1'($urandom_range(0, 1));
            s0  = 4'($urandom_range(0, 15));
            s1  = 4'($urandom_range(0, 15));
            eid = (sel == 2'b11) ? ~m_last : sel[1];
            eu  = eid ? up1 : up0;
            es  = eid ? s1 : s0;
            m_last = eid;
            for (int i = 1; i <= int'(es); i++) exp_q.push_back(walk(m_count, eu, i));
            m_count = walk(m_count, eu, int'(es));
            drive_req(0, sel[0], up0, s0);
            drive_req(1, sel[1], up1, s1);
            #1;
            n_cmp++; if ({req1_ready, req0_ready} !== (eid ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rand_grant it %0d: got %b expected id %0d", it, {req1_ready, req0_ready}, eid); end
            tick();
            drive_req(0, 1'b0, 1'b0, 4'd0);
            drive_req(1, 1'b0, 1'b0, 4'd0);
            n_cmp++; if (UpOrDown !== eu) begin n_err++; $display("FAIL rand_dir it %0d: got %b expected %b", it, UpOrDown, eu); end
            for (int i = 1; i <= int'(es); i++) begin
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rand_early_done it %0d: got %b expected 0", it, done); end
                tick();
                exp_c = exp_q.pop_front();
                n_cmp++; if (Count !== exp_c) begin n_err++; $display("FAIL rand_count it %0d step %0d: got %0d expected %0d", it, i, Count, exp_c); end
            end
            n_cmp++; if ({done, done_id} !== {1'b1, eid}) begin n_err++; $display("FAIL rand_done it %0d: got %b expected %b", it, {done, done_id}, {1'b1, eid}); end
            tick();
            n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rand_idle it %0d: got %b expected 00", it, {busy, done}); end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_req(0, 1'b0, 1'b0, 4'd0);
        drive_req(1, 1'b0, 1'b0, 4'd0);
        m_count = 4'd0;
        m_last  = 1'b1;
        test_reset();
        test_single_up();
        test_contention();
        test_wrap();
        test_zero_steps();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Arbitrated command sequencer wrapped around a 4-bit up/down counter datapath. Two requesters submit "count N steps up/down" commands over valid/ready handshakes. The block grants one requester at a time using round-robin, drives the counter for exactly N cycles, and signals completion with a one-cycle done pulse tagged with the requester id. It sits between the control logic and the counter, so software-style step commands never touch UpOrDown directly.

## Interface
- WIDTH, 4: counter width; Count wraps modulo 2^WIDTH.
- STEP_W, 4: width of the step-count field.

- Clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- req0_valid  in  1  requester 0 has a command pending.
- req0_up  in  1  requester 0 direction: 1 = up, 0 = down.
- req0_steps  in  STEP_W  requester 0 step count, 0..2^STEP_W-1.
- req0_ready  out  1  command 0 accepted this cycle; handshake completes when valid & ready.
- req1_valid, req1_up, req1_steps, req1_ready: same as requester 0, for requester 1.
- Count  out  WIDTH  current counter value.
- UpOrDown  out  1  direction of the active or last command.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  id of the completed requester; valid only while done = 1.

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- **IDLE**
  - Arbitration, when any reqX_valid is high:
    - Only one valid: grant that requester.
    - Both valid: grant the requester other than last_grant.
  - reqX_ready is combinational and asserted only for the granted requester, only in IDLE, and only while reset = 1.
  - On handshake, latch direction into UpOrDown, latch steps into remaining, latch id, and set last_grant = id.
  - If steps == 0, go to DONE. Otherwise go to RUN.
- **RUN**
  - Every edge: Count ± 1 modulo 2^WIDTH, and remaining − 1.
  - When remaining == 1 at the edge, go to DONE.
- **DONE**
  - done = 1 and done_id = latched id for exactly one cycle, then return to IDLE.
- Count is never cleared by commands; each command starts from the current value.
- Wrap-around is silent:
  - Up from 2^WIDTH−1 goes to 0.
  - Down from 0 goes to 2^WIDTH−1.
- Requesters must hold up and steps stable while valid is high and ready is low. They may drop valid before ready with no effect.
- Ready is never asserted outside IDLE. Valid seen during RUN or DONE simply waits.
- **Reset (reset = 0 at an edge)**, from any state:
  - Count = 0, UpOrDown = 0, state = IDLE, remaining = 0, last_grant = 1 (so requester 0 wins the first contention).
  - done = 0, busy = 0, both readies = 0 while reset is low.
  - An in-flight command is aborted with no done pulse.

## Timing
- Accept at edge k with steps N ≥ 1:
  - Count changes at edges k+1 .. k+N.
  - done is high in the cycle following edge k+N.
  - State is IDLE after edge k+N+1; the next accept is possible at edge k+N+2.
- Accept with steps = 0: done is high in the cycle after edge k; IDLE after k+1; Count is unchanged.
- Throughput: one command per N+2 cycles, back-to-back with no extra idle.
- busy rises the cycle after accept and falls the cycle after the done cycle.
- Under continuous contention, grants strictly alternate 0, 1, 0, 1, …

## Test plan
- **Reset:** hold reset = 0 for 2 cycles with req0_valid = 1.
  - Required: Count = 0, busy = 0, done = 0, and both readies = 0 during reset.
  - Required: req0_ready = 1 in the first cycle after release.
- **Single up command:** from Count = 0, req0 up, steps = 5.
  - Required: Count goes 1, 2, 3, 4, 5 on consecutive edges.
  - Required: done = 1 with done_id = 0 for one cycle, then Count holds at 5 and busy = 0.
- **Contention:** both valid and held; req0 up 3, req1 down 2, starting from 0.
  - Required: req0 is served first, Count goes 0→3, then req1 takes it 3→1.
  - Required: done_id reads 0 then 1.
  - Required: the next simultaneous request grants req0 again.
- **Wrap:** from Count = 14, command up 3, then down 2.
  - Required: Count goes 15, 0, 1, then 0, 15.
  - Required: UpOrDown is 1 during the first command and 0 during the second.
- **Zero steps:** req1 with steps = 0.
  - Required: done = 1 with done_id = 1 on the cycle after accept, Count unchanged, no RUN cycles.
- **Reset mid-RUN:** from Count = 0, down 10; pull reset low after 4 steps (Count = 12).
  - Required: Count = 0, no done pulse, busy = 0.
  - Required: the first subsequent contention grants req0.
